spi_master_word: RTL

Parametrised full-duplex SPI master: one word of WORD_WIDTH bits per transfer, SPI mode selectable per transfer, NUM_CS active-low chip selects with programmed setup/hold/gap timing, and the received MISO word returned with a one-cycle valid pulse. Successor to the fixed-mode, transmit-only SPI master in the SPI subsystem. Sits between the register/command logic in the i_Clk domain and the off-chip SPI pins; SCLK is generated from i_Clk.

---
 rtl/spi_master_word.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_word.sv
// Full-duplex word SPI master: per-transfer mode, NUM_CS active-low selects,
// setup/hold/gap timing of H = CLKS_PER_HALF_BIT cycles each, and the MISO word
// returned with a one-cycle o_RX_DV pulse.
// Ports: i_Clk/i_Rst_L clock and async active-low reset; i_TX_Word, i_Mode,
// i_CS_Sel, i_TX_DV request with o_TX_Ready; o_RX_Word/o_RX_DV result;
// o_SPI_Clk, o_SPI_MOSI, i_SPI_MISO, o_SPI_CS_n pins.
// Optional macro SPI_MASTER_LSB_FIRST_EN adds i_LSB_First (1 = LSB first).
module spi_master_word #(
  parameter int         WORD_WIDTH        = 40,
  parameter int         CLKS_PER_HALF_BIT = 2,
  parameter int         NUM_CS            = 1,
  parameter logic [1:0] DEFAULT_MODE      = 2'd0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [WORD_WIDTH-1:0] i_TX_Word,
  input  logic [1:0]            i_Mode,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] i_CS_Sel,
  input  logic                  i_TX_DV,
  output logic                  o_TX_Ready,
  output logic [WORD_WIDTH-1:0] o_RX_Word,
  output logic                  o_RX_DV,
  output logic                  o_SPI_Clk,
  input  logic                  i_SPI_MISO,
  output logic                  o_SPI_MOSI,
  output logic [NUM_CS-1:0]     o_SPI_CS_n
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic                  i_LSB_First
`endif
);

  localparam int W   = WORD_WIDTH;
  localparam int H   = CLKS_PER_HALF_BIT;
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CW  = $clog2(H);
  localparam int EW  = $clog2(2 * W + 1);
  localparam logic [CSW:0] NCS = NUM_CS[CSW:0];

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_GAP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [EW-1:0] edge_q;
  logic [W-1:0]  tx_sr;
  logic [W-1:0]  rx_sr;
  logic [1:0]    mode_q;
  logic          lsb_q;
  logic          lsb_in;

  logic tick;
  logic sel_ok;
  logic accept;
  logic sclk_edge;
  logic last_edge;
  logic leading;
  logic drive;
  logic sample;
  logic hold_done;
  logic gap_done;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = i_LSB_First;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(
    input logic [W-1:0] w,
    input logic         lsb
  );
    return lsb ? w[0] : w[W-1];
  endfunction

  function automatic logic [W-1:0] shift_out(
    input logic [W-1:0] w,
    input logic         lsb
  );
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign tick      = (cnt_q == CW'(H - 1));
  assign sel_ok    = ({1'b0, i_CS_Sel} < NCS);
  assign last_edge = (edge_q == EW'(2 * W - 1));
  // Even edge index = leading edge (away from CPOL).
  assign leading   = ~edge_q[0];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    sclk_edge = 1'b0;
    hold_done = 1'b0;
    gap_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_TX_DV && sel_ok) begin
          accept  = 1'b1;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sclk_edge = 1'b1;
          if (last_edge) state_d = CS_HOLD;
        end
      end
      CS_HOLD: begin
        if (tick) begin
          hold_done = 1'b1;
          state_d   = CS_GAP;
        end
      end
      CS_GAP: begin
        if (tick) begin
          gap_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // CPHA=0 drives on trailing edges (first bit preloaded at accept, none
  // after the final edge); CPHA=1 drives on leading edges.
  assign drive  = sclk_edge &&
                  (mode_q[0] ? leading : (!leading && !last_edge));
  assign sample = sclk_edge && (mode_q[0] ? !leading : leading);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      mode_q     <= DEFAULT_MODE;
      lsb_q      <= 1'b0;
      o_TX_Ready <= 1'b1;
      o_RX_Word  <= '0;
      o_RX_DV    <= 1'b0;
      o_SPI_Clk  <= DEFAULT_MODE[1];
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS_n <= '1;
    end else begin
      o_RX_DV <= 1'b0;
      if (state_q != IDLE && !tick) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      if (accept) begin
        mode_q     <= i_Mode;
        lsb_q      <= lsb_in;
        edge_q     <= '0;
        rx_sr      <= '0;
        o_TX_Ready <= 1'b0;
        o_SPI_Clk  <= i_Mode[1];
        o_SPI_CS_n <= ~(NUM_CS'(1) << i_CS_Sel);
        if (!i_Mode[0]) begin
          o_SPI_MOSI <= first_bit(i_TX_Word, lsb_in);
          tx_sr      <= shift_out(i_TX_Word, lsb_in);
        end else begin
          tx_sr <= i_TX_Word;
        end
      end
      if (sclk_edge) begin
        o_SPI_Clk <= ~o_SPI_Clk;
        edge_q    <= edge_q + EW'(1);
      end
      if (drive) begin
        o_SPI_MOSI <= first_bit(tx_sr, lsb_q);
        tx_sr      <= shift_out(tx_sr, lsb_q);
      end
      if (sample) begin
        rx_sr <= lsb_q ? {i_SPI_MISO, rx_sr[W-1:1]}
                       : {rx_sr[W-2:0], i_SPI_MISO};
      end
      if (hold_done) begin
        o_SPI_CS_n <= '1;
        o_RX_Word  <= rx_sr;
        o_RX_DV    <= 1'b1;
      end
      if (gap_done) begin
        o_TX_Ready <= 1'b1;
      end
    end
  end

endmodule
